// File: rtl/move_queue_scheduler_pkg.sv
// Shared definitions for the move queue scheduler: the FSM state encoding
// and the default queue depth (log2 of entries).
package move_queue_scheduler_pkg;

  localparam int DEFAULT_DEPTH_BITS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } move_state_e;

endpackage

// File: rtl/move_ring_fifo.sv
// Ring buffer of packed move words. Pointers carry one extra wrap bit so
// full and empty can be told apart when the index bits match.
// Optional macro HALT_EN adds a flush input that drops every queued entry.
module move_ring_fifo
  import move_queue_scheduler_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS,
  parameter int DATA_W     = 193
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
`ifdef HALT_EN
  input  logic                flush,
`endif
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_BITS:0] fill_level
);

  localparam int ENTRIES = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] PTR_ONE = 1;

  logic [DATA_W-1:0]   mem [ENTRIES];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
  end

  // Pointer update; flush snaps the read pointer onto the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
`ifdef HALT_EN
      if (flush) rd_ptr <= wr_ptr;
      else if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
`else
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
`endif
    end
  end

  // Status decode from the wrap bit and the index bits.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                 (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
    fill_level = wr_ptr - rd_ptr;
    rd_data    = mem[rd_ptr[DEPTH_BITS-1:0]];
  end

endmodule

// File: rtl/move_queue_scheduler.sv
// Move queue scheduler: buffers moves in a ring FIFO and feeds them one at a
// time to a DDA timer (LOAD pops and registers the head, START pulses
// dda_start, RUN waits for dda_done).
// Optional macro HALT_EN adds a halt input that flushes the queue and
// returns the FSM to IDLE without signalling move_done.
// Handshake: an enqueue happens on every rising edge where wr_valid and
// wr_ready are both high; wr_ready is low only when the queue is full, and
// wr_valid while full is simply ignored (no write, no pointer change).
module move_queue_scheduler
  import move_queue_scheduler_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS,
  parameter int WORD_W     = 64
) (
  input  logic                CLK,
  input  logic                resetn,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                wr_dir,
  input  logic [WORD_W-1:0]   wr_duration,
  input  logic [WORD_W-1:0]   wr_increment,
  input  logic [WORD_W-1:0]   wr_incinc,
  output logic                out_dir,
  output logic [WORD_W-1:0]   out_duration,
  output logic [WORD_W-1:0]   out_increment,
  output logic [WORD_W-1:0]   out_incinc,
  output logic                dda_start,
  input  logic                dda_done,
  output logic [DEPTH_BITS:0] fill_level,
  output logic                buffer_dtr,
  output logic                move_done,
`ifdef HALT_EN
  input  logic                halt,
`endif
  output move_state_e         fsm_state
);

  localparam int ENTRY_W = 3 * WORD_W + 1;

  move_state_e        state;
  move_state_e        state_next;
  logic               load_en;
  logic               push;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;

`ifdef HALT_EN
  // A write offered in the same cycle as halt is dropped along with the queue.
  assign push = wr_valid && !full && !halt;
`else
  assign push = wr_valid && !full;
`endif

  assign wr_ready  = !full;
  // fill_level never exceeds the depth, so its top bit is set only when full.
  assign buffer_dtr = !fill_level[DEPTH_BITS];
  assign fsm_state  = state;

  move_ring_fifo #(
    .DEPTH_BITS(DEPTH_BITS),
    .DATA_W    (ENTRY_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (resetn),
    .push      (push),
    .pop       (load_en),
`ifdef HALT_EN
    .flush     (halt),
`endif
    .wr_data   ({wr_dir, wr_duration, wr_increment, wr_incinc}),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .fill_level(fill_level)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode plus the one-cycle strobes derived from the state.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    dda_start  = 1'b0;
    move_done  = 1'b0;
    case (state)
      IDLE:  if (!empty) state_next = LOAD;
      LOAD: begin
        load_en    = 1'b1;
        state_next = START;
      end
      START: begin
        dda_start  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (dda_done) begin
          if (!empty) begin
            state_next = LOAD;
          end else begin
            state_next = IDLE;
            move_done  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef HALT_EN
    if (halt) begin
      state_next = IDLE;
      load_en    = 1'b0;
      dda_start  = 1'b0;
      move_done  = 1'b0;
    end
`endif
  end

  // Active move register: captured in LOAD and held until the next LOAD.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      out_dir       <= 1'b0;
      out_duration  <= '0;
      out_increment <= '0;
      out_incinc    <= '0;
    end else if (load_en) begin
      {out_dir, out_duration, out_increment, out_incinc} <= head;
    end
  end

endmodule

// File: tb/tb_move_queue_scheduler.sv
// Directed testbench for move_queue_scheduler (default depth 4, 64-bit words).
// Build with HALT_EN defined to also exercise the halt path.
module tb_move_queue_scheduler;
  import move_queue_scheduler_pkg::*;

  localparam int WORD_W     = 64;
  localparam int DEPTH_BITS = 2;
  localparam int MOVE_W     = 3 * WORD_W + 1;

  logic                CLK;
  logic                resetn;
  logic                wr_valid;
  logic                wr_ready;
  logic                wr_dir;
  logic [WORD_W-1:0]   wr_duration;
  logic [WORD_W-1:0]   wr_increment;
  logic [WORD_W-1:0]   wr_incinc;
  logic                out_dir;
  logic [WORD_W-1:0]   out_duration;
  logic [WORD_W-1:0]   out_increment;
  logic [WORD_W-1:0]   out_incinc;
  logic                dda_start;
  logic                dda_done;
  logic [DEPTH_BITS:0] fill_level;
  logic                buffer_dtr;
  logic                move_done;
  move_state_e         fsm_state;
`ifdef HALT_EN
  logic                halt;
`endif

  logic [MOVE_W-1:0] out_word;
  assign out_word = {out_dir, out_duration, out_increment, out_incinc};

  int checks   = 0;
  int failures = 0;
  logic [MOVE_W-1:0] exp_q[$];

  move_queue_scheduler #(
    .DEPTH_BITS(DEPTH_BITS),
    .WORD_W    (WORD_W)
  ) dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_dir       (wr_dir),
    .wr_duration  (wr_duration),
    .wr_increment (wr_increment),
    .wr_incinc    (wr_incinc),
    .out_dir      (out_dir),
    .out_duration (out_duration),
    .out_increment(out_increment),
    .out_incinc   (out_incinc),
    .dda_start    (dda_start),
    .dda_done     (dda_done),
    .fill_level   (fill_level),
    .buffer_dtr   (buffer_dtr),
    .move_done    (move_done),
`ifdef HALT_EN
    .halt         (halt),
`endif
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [MOVE_W-1:0] obs,
                       input logic [MOVE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [MOVE_W-1:0] mk(input logic dir, input logic [63:0] dur,
                                           input logic [63:0] inc, input logic [63:0] incinc);
    return {dir, dur, inc, incinc};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic enq(input logic [MOVE_W-1:0] m, input bit accept);
    {wr_dir, wr_duration, wr_increment, wr_incinc} = m;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    if (accept) exp_q.push_back(m);
    settle();
  endtask

  // dda_start must be high now and the out_* fields must hold the oldest
  // accepted move.
  task automatic expect_start(input string tag);
    check({tag, " dda_start"}, MOVE_W'(dda_start), MOVE_W'(1'b1));
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard observed=start expected=no_move", tag);
    end else begin
      check({tag, " out"}, out_word, exp_q.pop_front());
    end
  endtask

  // Enqueue into an empty idle queue: dda_start appears on the third edge.
  task automatic launch_first(input string tag, input logic [MOVE_W-1:0] m);
    enq(m, 1'b1);
    check({tag, " e1 start"}, MOVE_W'(dda_start), '0);
    check({tag, " e1 fill"}, MOVE_W'(fill_level), MOVE_W'(1));
    tick();
    check({tag, " e2 state"}, MOVE_W'(fsm_state), MOVE_W'(LOAD));
    check({tag, " e2 start"}, MOVE_W'(dda_start), '0);
    tick();
    expect_start({tag, " e3"});
    check({tag, " e3 fill"}, MOVE_W'(fill_level), '0);
    tick();
    check({tag, " run"}, MOVE_W'(fsm_state), MOVE_W'(RUN));
    check({tag, " run start"}, MOVE_W'(dda_start), '0);
  endtask

  // Complete the active move; if more are queued, the next one must launch
  // two edges after dda_done.
  task automatic finish_move(input string tag, input bit last);
    check({tag, " in run"}, MOVE_W'(fsm_state), MOVE_W'(RUN));
    dda_done = 1'b1;
    settle();
    check({tag, " move_done"}, MOVE_W'(move_done), MOVE_W'(last));
    tick();
    dda_done = 1'b0;
    settle();
    if (last) begin
      check({tag, " idle"}, MOVE_W'(fsm_state), MOVE_W'(IDLE));
      check({tag, " done low"}, MOVE_W'(move_done), '0);
    end else begin
      check({tag, " load"}, MOVE_W'(fsm_state), MOVE_W'(LOAD));
      check({tag, " load start"}, MOVE_W'(dda_start), '0);
      tick();
      expect_start(tag);
      tick();
      check({tag, " run again"}, MOVE_W'(fsm_state), MOVE_W'(RUN));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " state"}, MOVE_W'(fsm_state), MOVE_W'(IDLE));
    check({tag, " out"}, out_word, '0);
    check({tag, " start"}, MOVE_W'(dda_start), '0);
    check({tag, " done"}, MOVE_W'(move_done), '0);
    check({tag, " fill"}, MOVE_W'(fill_level), '0);
    check({tag, " ready"}, MOVE_W'(wr_ready), MOVE_W'(1'b1));
    check({tag, " dtr"}, MOVE_W'(buffer_dtr), MOVE_W'(1'b1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [MOVE_W-1:0] m [8];
    int pulses;
    m[0] = mk(1'b1, 64'd100, 64'd5, 64'd0);
    m[1] = mk(1'b0, 64'd11, 64'd1, 64'd2);
    m[2] = mk(1'b1, 64'd22, 64'd3, 64'd4);
    m[3] = mk(1'b0, 64'd33, 64'hFFFF_FFFF_FFFF_FFFF, 64'd6);
    m[4] = mk(1'b1, 64'd44, 64'd7, 64'h8000_0000_0000_0000);
    m[5] = mk(1'b0, 64'd55, 64'd9, 64'd10);
    m[6] = mk(1'b1, 64'hDEAD_BEEF, 64'd66, 64'd77);
    m[7] = mk(1'b0, 64'd88, 64'd99, 64'd111);

    resetn = 1'b0; wr_valid = 1'b0; dda_done = 1'b0;
    wr_dir = 1'b0; wr_duration = '0; wr_increment = '0; wr_incinc = '0;
`ifdef HALT_EN
    halt = 1'b0;
`endif
    tick(); tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    // Single move into an empty queue, then drain.
    launch_first("single", m[0]);
    finish_move("single end", 1'b1);

    // dda_done while idle is ignored.
    dda_done = 1'b1;
    settle();
    check("idle done ignored", MOVE_W'(move_done), '0);
    tick();
    dda_done = 1'b0;
    settle();
    check("idle stays", MOVE_W'(fsm_state), MOVE_W'(IDLE));

    // Fill the queue while the DDA sits in RUN.
    enq(m[1], 1'b1);
    enq(m[2], 1'b1);
    enq(m[3], 1'b1);
    expect_start("fill first");
    enq(m[4], 1'b1);
    check("fill state run", MOVE_W'(fsm_state), MOVE_W'(RUN));
    check("fill 3", MOVE_W'(fill_level), MOVE_W'(3));
    check("fill 3 ready", MOVE_W'(wr_ready), MOVE_W'(1'b1));
    enq(m[5], 1'b1);
    check("full fill", MOVE_W'(fill_level), MOVE_W'(4));
    check("full ready", MOVE_W'(wr_ready), '0);
    check("full dtr", MOVE_W'(buffer_dtr), '0);
    enq(m[6], 1'b0);
    check("overflow fill", MOVE_W'(fill_level), MOVE_W'(4));
    check("out held", out_word, m[1]);

    // Pop down to two queued.
    finish_move("pop a", 1'b0);
    check("pop a fill", MOVE_W'(fill_level), MOVE_W'(3));
    check("pop a ready", MOVE_W'(wr_ready), MOVE_W'(1'b1));
    finish_move("pop b", 1'b0);
    check("pop b fill", MOVE_W'(fill_level), MOVE_W'(2));

    // dda_done with two queued; enqueue lands on the popping LOAD edge.
    dda_done = 1'b1;
    settle();
    check("simul done low", MOVE_W'(move_done), '0);
    tick();
    dda_done = 1'b0;
    settle();
    check("simul load", MOVE_W'(fsm_state), MOVE_W'(LOAD));
    check("simul fill before", MOVE_W'(fill_level), MOVE_W'(2));
    enq(m[7], 1'b1);
    expect_start("simul");
    check("simul fill after", MOVE_W'(fill_level), MOVE_W'(2));
    tick();

    // Drain everything; move_done pulses exactly once.
    finish_move("drain a", 1'b0);
    finish_move("drain b", 1'b0);
    check("drain fill", MOVE_W'(fill_level), '0);
    finish_move("drain end", 1'b1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (move_done || dda_start) pulses++;
    end
    check("drain quiet", MOVE_W'(pulses), '0);
    check("drain idle", MOVE_W'(fsm_state), MOVE_W'(IDLE));

    // Reset in RUN with three queued.
    enq(m[1], 1'b1);
    enq(m[2], 1'b1);
    enq(m[3], 1'b1);
    expect_start("rst pre");
    enq(m[4], 1'b1);
    check("rst pre fill", MOVE_W'(fill_level), MOVE_W'(3));
    #2;
    resetn = 1'b0;
    settle();
    check_reset_outputs("rst mid");
    exp_q.delete();
    tick(); tick();
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dda_start || fsm_state != IDLE) pulses++;
    end
    check("rst quiet", MOVE_W'(pulses), '0);
    launch_first("post rst", m[5]);
    finish_move("post rst end", 1'b1);

`ifdef HALT_EN
    // Halt in RUN with two queued; a write in the halt cycle is dropped.
    enq(m[1], 1'b1);
    enq(m[2], 1'b1);
    enq(m[3], 1'b1);
    expect_start("halt pre");
    tick();
    check("halt pre run", MOVE_W'(fsm_state), MOVE_W'(RUN));
    check("halt pre fill", MOVE_W'(fill_level), MOVE_W'(2));
    halt = 1'b1;
    {wr_dir, wr_duration, wr_increment, wr_incinc} = m[6];
    wr_valid = 1'b1;
    settle();
    check("halt done low", MOVE_W'(move_done), '0);
    tick();
    halt = 1'b0;
    wr_valid = 1'b0;
    settle();
    exp_q.delete();
    check("halt fill", MOVE_W'(fill_level), '0);
    check("halt idle", MOVE_W'(fsm_state), MOVE_W'(IDLE));
    check("halt after done", MOVE_W'(move_done), '0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dda_start || move_done) pulses++;
    end
    check("halt quiet", MOVE_W'(pulses), '0);
    launch_first("post halt", m[7]);
    finish_move("post halt end", 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
